cipher_serializer: RTL and testbench

Downstream consumer of the 64-bit cipher-word registers in the ASCON-128 datapath. It captures NB_BLOCKS consecutive cipher words, one per cipher-register load strobe. It then streams them out MSB-first as bytes over a valid/ready handshake toward the byte-oriented output interface, such as a UART TX. It reports completion, busy status and protocol errors to the top-level FSM.

---
 rtl/cipher_serializer_pkg.sv | 14 +
 rtl/cipher_serializer.sv | 127 ++++++++++++
 tb/tb_cipher_serializer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_serializer_pkg.sv
// Shared ASCON datapath definitions used by the cipher-word serializer.
package ascon_pack;

    localparam int CIPHER_W = 64;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND,
        S_DONE
    } ser_state_t;

endpackage

// File: rtl/cipher_serializer.sv
// Collects NB_BLOCKS cipher words, then streams them out MSB-first as bytes
// over a valid/ready handshake, reporting busy, done and overflow status.
module cipher_serializer
    import ascon_pack::*;
#(
    parameter int NB_BLOCKS = 4
)
(
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                cipher_valid_i,
    input  logic [CIPHER_W-1:0] cipher_i,
    output logic [BYTE_W-1:0]   byte_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o
);

    // A single-word message still needs a one-bit write index.
    localparam int WI_W = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
    localparam int BC_W = $clog2(8 * NB_BLOCKS);

    localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NB_BLOCKS - 1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(8 * NB_BLOCKS - 1);

    ser_state_t state;
    ser_state_t state_next;

    logic [CIPHER_W-1:0] buffer [NB_BLOCKS];
    logic [WI_W-1:0]     wr_idx;
    logic [BC_W-1:0]     byte_cnt;
    logic                overflow;

    logic                capture;
    logic                transfer;
    logic [WI_W-1:0]     word_sel;
    logic [5:0]          lane_base;
    logic [CIPHER_W-1:0] cur_word;

    // start_i always wins over a same-cycle cipher word.
    assign capture  = (state == S_COLLECT) && cipher_valid_i && !start_i;
    assign transfer = (state == S_SEND) && byte_ready_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_i) state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (start_i) begin
                    state_next = S_COLLECT;
                end else if (capture && wr_idx == LAST_WORD) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (start_i) begin
                    state_next = S_COLLECT;
                end else if (transfer && byte_cnt == LAST_BYTE) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = start_i ? S_COLLECT : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters freeze on their final value; the state change ends the phase.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_idx   <= '0;
            byte_cnt <= '0;
        end else if (start_i) begin
            wr_idx   <= '0;
            byte_cnt <= '0;
        end else begin
            if (capture && wr_idx != LAST_WORD) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (transfer && byte_cnt != LAST_BYTE) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            overflow <= 1'b0;
        end else if (start_i) begin
            overflow <= 1'b0;
        end else if (cipher_valid_i && state != S_COLLECT) begin
            overflow <= 1'b1;
        end
    end

    // Buffer contents are only observable in SEND, so no reset is needed.
    always_ff @(posedge clock_i) begin
        if (capture) begin
            buffer[wr_idx] <= cipher_i;
        end
    end

    assign word_sel  = WI_W'(byte_cnt >> 3);
    assign lane_base = {~byte_cnt[2:0], 3'b000};
    assign cur_word  = buffer[word_sel];

    assign byte_o       = (state == S_SEND) ? cur_word[lane_base +: BYTE_W] : '0;
    assign byte_valid_o = (state == S_SEND);
    assign busy_o       = (state == S_COLLECT) || (state == S_SEND);
    assign done_o       = (state == S_DONE);
    assign overflow_o   = overflow;

endmodule

// File: tb/tb_cipher_serializer.sv
// Scoreboard bench for cipher_serializer: the driver queues the expected byte
// stream of every message, and a monitor pops and compares accepted bytes.
module tb_cipher_serializer;

    localparam int NB     = 4;
    localparam int NBYTES = 8 * NB;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        cipher_valid_i = 1'b0;
    logic [63:0] cipher_i = '0;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int accepted = 0;
    int ready_mode = 0;
    int ready_phase = 0;

    logic [7:0] exp_q[$];
    logic [7:0] held_byte = '0;
    logic       held = 1'b0;

    cipher_serializer #(.NB_BLOCKS(NB)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .cipher_valid_i (cipher_valid_i),
        .cipher_i       (cipher_i),
        .byte_o         (byte_o),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Sink readiness: 0 = always ready, 1 = repeating 1,0,0,1, else random.
    always @(posedge clock_i) begin
        #1;
        case (ready_mode)
            0: byte_ready_i = 1'b1;
            1: begin
                byte_ready_i = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                ready_phase++;
            end
            default: byte_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares each accepted byte with the scoreboard head.
    always @(negedge clock_i) begin
        if (held && byte_valid_o) checkOutput("stall_hold", byte_o, held_byte);
        held = 1'b0;
        if (!reset_i && !start_i) begin
            if (byte_valid_o && byte_ready_i) begin
                if (exp_q.size() == 0) checkOutput("unexpected_byte", byte_valid_o, 0);
                else checkOutput("byte", byte_o, exp_q.pop_front());
                accepted++;
            end else if (byte_valid_o) begin
                held = 1'b1;
                held_byte = byte_o;
            end
            if (done_o) begin
                done_count++;
                checkOutput("done_after_last", exp_q.size(), 0);
            end
        end
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [63:0] w);
        start_i = s;
        cipher_valid_i = v;
        cipher_i = w;
        step();
        start_i = 1'b0;
        cipher_valid_i = 1'b0;
    endtask

    // Reference model: word 0 first, most significant byte first.
    task automatic push_message(input logic [63:0] w [NB]);
        for (int i = 0; i < NB; i++)
            for (int b = 7; b >= 0; b--)
                exp_q.push_back(8'((w[i] >> (8 * b)) & 64'hFF));
    endtask

    task automatic send_words(input logic [63:0] w [NB], input int max_gap);
        for (int i = 0; i < NB; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) step();
            applyStimulus(1'b0, 1'b1, w[i]);
        end
    endtask

    task automatic start_message(input logic [63:0] w [NB]);
        exp_q.delete();
        applyStimulus(1'b1, 1'b0, 64'h0);
        push_message(w);
    endtask

    task automatic wait_done(input string name, input int target);
        int n = 0;
        while (done_count < target && n < 400) begin
            step();
            n++;
        end
        repeat (3) step();
        checkOutput(name, done_count, target);
    endtask

    task automatic wait_accepted(input int target);
        int n = 0;
        while (accepted < target && n < 400) begin
            step();
            n++;
        end
        checkOutput("accept_timeout", (accepted >= target), 1);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_byte"}, byte_o, 8'h00);
        checkOutput({tag, "_valid"}, byte_valid_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_overflow"}, overflow_o, 0);
    endtask

    initial begin
        logic [63:0] nominal [NB];
        logic [63:0] words [NB];
        int d0;
        int n;
        nominal[0] = 64'h0123456789ABCDEF;
        nominal[1] = 64'h1111111111111111;
        nominal[2] = 64'h2222222222222222;
        nominal[3] = 64'hFEDCBA9876543210;

        repeat (2) step();
        reset_i = 1'b0;
        check_reset_values("reset");

        // Nominal message with ready held high: one byte per cycle.
        ready_mode = 0;
        d0 = done_count;
        start_message(nominal);
        checkOutput("busy_collect", busy_o, 1);
        send_words(nominal, 0);
        checkOutput("first_valid", byte_valid_o, 1);
        checkOutput("first_byte", byte_o, 8'h01);
        n = 0;
        while (!done_o && n < 100) begin
            step();
            n++;
        end
        checkOutput("throughput_cycles", n, NBYTES);
        checkOutput("done_valid_low", byte_valid_o, 0);
        checkOutput("done_busy_low", busy_o, 0);
        wait_done("nominal_done", d0 + 1);
        checkOutput("nominal_overflow", overflow_o, 0);

        // Backpressure with the 1,0,0,1 ready pattern.
        ready_mode = 1;
        d0 = done_count;
        start_message(nominal);
        send_words(nominal, 0);
        wait_done("backpressure_done", d0 + 1);

        // Stray words in IDLE and in SEND raise the sticky overflow flag.
        ready_mode = 0;
        applyStimulus(1'b0, 1'b1, {$urandom, $urandom});
        checkOutput("overflow_idle", overflow_o, 1);
        d0 = done_count;
        start_message(nominal);
        checkOutput("overflow_start_clears", overflow_o, 0);
        send_words(nominal, 0);
        repeat (3) step();
        applyStimulus(1'b0, 1'b1, {$urandom, $urandom});
        checkOutput("overflow_send", overflow_o, 1);
        wait_done("overflow_done", d0 + 1);
        checkOutput("overflow_sticky", overflow_o, 1);

        // Abort after byte 10, then stream a fresh message from its byte 0.
        ready_mode = 2;
        d0 = done_count;
        for (int i = 0; i < NB; i++) words[i] = {$urandom, $urandom};
        start_message(words);
        send_words(words, 0);
        n = accepted;
        wait_accepted(n + 10);
        for (int i = 0; i < NB; i++) words[i] = {$urandom, $urandom};
        start_message(words);
        checkOutput("abort_valid_drop", byte_valid_o, 0);
        checkOutput("abort_no_done", done_count, d0);
        send_words(words, 2);
        wait_done("abort_done", d0 + 1);

        // start_i with a simultaneous word: the word is dropped silently.
        ready_mode = 0;
        d0 = done_count;
        exp_q.delete();
        applyStimulus(1'b1, 1'b1, 64'hAAAAAAAAAAAAAAAA);
        push_message(nominal);
        checkOutput("simul_overflow", overflow_o, 0);
        send_words(nominal, 0);
        wait_done("simul_done", d0 + 1);
        checkOutput("simul_overflow_end", overflow_o, 0);

        // Reset in the middle of SEND.
        ready_mode = 0;
        d0 = done_count;
        start_message(nominal);
        send_words(nominal, 0);
        n = accepted;
        wait_accepted(n + 5);
        reset_i = 1'b1;
        exp_q.delete();
        step();
        reset_i = 1'b0;
        check_reset_values("midreset");
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("midreset_quiet", byte_valid_o, 0);
        end
        checkOutput("midreset_no_done", done_count, d0);

        // Randomized messages with random ready and random word gaps.
        ready_mode = 2;
        for (int m = 0; m < 6; m++) begin
            d0 = done_count;
            repeat ($urandom_range(0, 3)) step();
            for (int i = 0; i < NB; i++) words[i] = {$urandom, $urandom};
            start_message(words);
            send_words(words, 3);
            wait_done("random_done", d0 + 1);
        end

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
